// File: rtl/sum_ascii_tx.sv
// sum_ascii_tx: turns an unsigned adder result into two ASCII decimal
// digits plus a line feed, and sends them one byte per valid/ready handshake.
// Values above 99 print as "??" followed by the line feed.
module sum_ascii_tx #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_TX_TENS,
        S_TX_ONES,
        S_TX_EOL
    } state_t;

    localparam logic [WIDTH-1:0] TEN      = WIDTH'(10);
    localparam logic [7:0]       CH_ZERO  = 8'h30;
    localparam logic [7:0]       CH_QUEST = 8'h3F;
    localparam logic [7:0]       CH_LF    = 8'h0A;

    state_t           r_state;
    logic [3:0]       r_tens;
    logic [WIDTH-1:0] r_rem;
    logic             r_ovf;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;

    logic             w_rem_ge10;
    logic             w_tens_max;
    logic             w_conv_ovf;
    logic             w_tx_fire;
    logic [7:0]       w_tens_char;
    logic [7:0]       w_ones_char;

    // Repeated-subtraction divider conditions and the characters to load.
    // The tens character is loaded on the same edge that may set ovf, so it
    // looks at the overflow condition directly rather than at r_ovf.
    always_comb begin
        w_rem_ge10  = (r_rem >= TEN);
        w_tens_max  = (r_tens == 4'd9);
        w_conv_ovf  = w_rem_ge10 && w_tens_max;
        w_tx_fire   = r_tx_valid && tx_ready;
        w_tens_char = w_conv_ovf ? CH_QUEST : (CH_ZERO + {4'b0000, r_tens});
        w_ones_char = r_ovf      ? CH_QUEST : (CH_ZERO + {4'b0000, r_rem[3:0]});
    end

    // Main FSM: accept, divide by 10 one step per cycle, then send three bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tens     <= 4'd0;
            r_rem      <= '0;
            r_ovf      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rem   <= in_value;
                        r_tens  <= 4'd0;
                        r_ovf   <= 1'b0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (w_rem_ge10 && !w_tens_max) begin
                        r_rem  <= r_rem - TEN;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        // rem < 10 means the digits are final; rem >= 10 with
                        // tens at 9 means the value does not fit in two digits.
                        if (w_rem_ge10) begin
                            r_ovf <= 1'b1;
                        end
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_tens_char;
                        r_state    <= S_TX_TENS;
                    end
                end
                S_TX_TENS: begin
                    if (w_tx_fire) begin
                        r_tx_data <= w_ones_char;
                        r_state   <= S_TX_ONES;
                    end
                end
                S_TX_ONES: begin
                    if (w_tx_fire) begin
                        r_tx_data <= CH_LF;
                        r_state   <= S_TX_EOL;
                    end
                end
                S_TX_EOL: begin
                    // tx_data keeps the line feed; it only changes when a
                    // TX state is entered again.
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs come from registered state; in_ready is additionally gated by
    // rst so nothing is offered while the block is being reset.
    always_comb begin
        in_ready = (r_state == S_IDLE) && !rst;
        busy     = (r_state != S_IDLE);
        tx_valid = r_tx_valid;
        tx_data  = r_tx_data;
    end

endmodule

// File: tb/tb_sum_ascii_tx.sv
// Bench for sum_ascii_tx: directed steps plus randomized values, checked
// against a decimal-formatting model; covers WIDTH=6 and WIDTH=7 instances.
module tb_sum_ascii_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       tx_ready;
    logic       sel;          // 0: WIDTH=6 instance, 1: WIDTH=7 instance
    logic [6:0] in_value;

    logic       ir6, tv6, bz6, ir7, tv7, bz7;
    logic [7:0] td6, td7;
    logic       iv6, iv7;
    logic       o_ir, o_tv, o_busy;
    logic [7:0] o_td;

    int checks   = 0;
    int failures = 0;
    logic [7:0] got[$];
    logic tog = 1'b0;

    always #5 clk = ~clk;

    assign iv6 = in_valid & ~sel;
    assign iv7 = in_valid &  sel;
    assign o_ir   = sel ? ir7 : ir6;
    assign o_tv   = sel ? tv7 : tv6;
    assign o_busy = sel ? bz7 : bz6;
    assign o_td   = sel ? td7 : td6;

    sum_ascii_tx #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6),
        .in_value(in_value[5:0]), .tx_valid(tv6), .tx_ready(tx_ready),
        .tx_data(td6), .busy(bz6)
    );

    sum_ascii_tx #(.WIDTH(7)) dut7 (
        .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7),
        .in_value(in_value), .tx_valid(tv7), .tx_ready(tx_ready),
        .tx_data(td7), .busy(bz7)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal rendering of v: two digits with leading zero, "??" above 99.
    function automatic void model(input int v, output logic [7:0] e0,
                                  output logic [7:0] e1, output int lat);
        if (v > 99) begin
            e0 = 8'h3F; e1 = 8'h3F; lat = 10;
        end else begin
            e0 = 8'(48 + v / 10); e1 = 8'(48 + v % 10); lat = v / 10 + 1;
        end
    endfunction

    // Wait at negedges for in_ready, then present v for one accepting edge.
    task automatic accept(input int v, input bit hold_valid);
        int budget = 50;
        while (!o_ir && budget > 0) begin @(negedge clk); budget--; end
        chk("in_ready_before_accept", o_ir, 1);
        in_value = 7'(v);
        in_valid = 1'b1;
        @(negedge clk);
        if (!hold_valid) in_valid = 1'b0;
        chk("busy_after_accept", o_busy, 1);
        chk("in_ready_after_accept", o_ir, 0);
    endtask

    // Count edges from the accepting edge until tx_valid appears.
    task automatic wait_tx(input int exp_lat, input string tag);
        int cnt = 0;
        while (!o_tv && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        chk(tag, cnt, exp_lat);
    endtask

    // Collect n transferred bytes; mode 0 ready always, 1 toggling, 2 random.
    task automatic collect(input int n, input int mode);
        int   budget   = 80 * n;
        bit   have_hold = 0;
        logic [7:0] held = 8'h00;
        logic r;
        while (got.size() < n && budget > 0) begin
            chk("in_ready_vs_busy", o_ir, !o_busy);
            if (have_hold) chk("valid_held", o_tv, 1);
            if (o_tv) begin
                chk("busy_while_tx", o_busy, 1);
                if (have_hold) chk("data_held", o_td, held);
                case (mode)
                    0: r = 1'b1;
                    1: begin r = tog; tog = ~tog; end
                    default: r = 1'($urandom_range(0, 1));
                endcase
                tx_ready = r;
                if (r) begin
                    got.push_back(o_td);
                    have_hold = 0;
                end else begin
                    have_hold = 1;
                    held = o_td;
                end
            end else begin
                have_hold = 0;
                tx_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            budget--;
        end
        chk("collect_timeout", got.size(), n);
        tx_ready = 1'b1;
    endtask

    // One complete transaction with byte, latency and return-to-idle checks.
    task automatic run(input int v, input int mode);
        logic [7:0] e0, e1;
        int lat;
        model(v, e0, e1, lat);
        got.delete();
        accept(v, 1'b0);
        wait_tx(lat, "latency");
        collect(3, mode);
        if (got.size() == 3) begin
            chk("byte_tens", got[0], e0);
            chk("byte_ones", got[1], e1);
            chk("byte_eol",  got[2], 8'h0A);
        end
        chk("idle_tx_valid", o_tv, 0);
        chk("idle_in_ready", o_ir, 1);
        chk("idle_busy", o_busy, 0);
    endtask

    initial begin
        logic [7:0] e0, e1;
        int lat;
        rst = 1'b1; in_valid = 1'b0; tx_ready = 1'b1; sel = 1'b0; in_value = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready_low", o_ir, 0);
        chk("rst_tx_valid", o_tv, 0);
        chk("rst_tx_data", o_td, 8'h00);
        chk("rst_busy", o_busy, 0);
        rst = 1'b0;
        #1 chk("rst_release_in_ready", o_ir, 1);
        @(negedge clk);

        // Directed values: 0, 31 with ready high, 62 with ready toggling
        run(0, 0);
        run(31, 0);
        run(62, 1);
        run(7, 2);

        // in_valid held high with 9 then 10 queued behind it
        got.delete();
        accept(9, 1'b1);
        in_value = 7'd10;
        wait_tx(1, "latency_9");
        collect(3, 0);
        chk("b2b_in_ready_after_eol", o_ir, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_accept", o_busy, 1);
        wait_tx(2, "latency_10");
        collect(6, 0);
        if (got.size() == 6) begin
            chk("b2b_0", got[0], 8'h30); chk("b2b_1", got[1], 8'h39);
            chk("b2b_2", got[2], 8'h0A); chk("b2b_3", got[3], 8'h31);
            chk("b2b_4", got[4], 8'h30); chk("b2b_5", got[5], 8'h0A);
        end
        chk("b2b_idle", o_ir, 1);

        // Reset in TX_ONES with tx_ready low
        got.delete();
        accept(45, 1'b0);
        wait_tx(5, "latency_45");
        collect(1, 0);
        chk("pre_rst_in_ones", o_tv, 1);
        tx_ready = 1'b0;
        rst = 1'b1;
        #1 chk("rst_in_ready_gated", o_ir, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_tx_valid", o_tv, 0);
        chk("mid_rst_tx_data", o_td, 8'h00);
        chk("mid_rst_in_ready", o_ir, 1);
        chk("mid_rst_busy", o_busy, 0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_bytes_after_rst", o_tv, 0);
        end

        // Randomized values on the WIDTH=6 instance
        for (int i = 0; i < 12; i++) run(int'($urandom_range(0, 63)), int'($urandom_range(0, 2)));

        // WIDTH=7 instance: overflow and the largest two-digit value
        sel = 1'b1;
        @(negedge clk);
        run(127, 0);
        run(99, 1);
        run(100, 2);
        for (int i = 0; i < 6; i++) run(int'($urandom_range(0, 127)), int'($urandom_range(0, 2)));
        model(99, e0, e1, lat);
        chk("model_sanity_99_latency_in_model", lat, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
